regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised successor of the decode-stage register file.
- N-read / 1-write register array with an integrated writeback source mux (ALU / memory / link).
- Per-register pending scoreboard that stalls issue on load-use hazards.
- Sits between fetch/decode and execute; writeback arrives from the MEM/WB side.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, minimum 4.
- NUM_RD, 2, number of independent read ports.
- AW, $clog2(NREGS), register address width (derived, not overridden).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_en  in  NUM_RD  read-port-used qualifiers, for stall generation only.
- rd_data  out  NUM_RD*XLEN  packed read data.
- rd_busy  out  NUM_RD  port i's register has a pending write.
- stall  out  1  OR over i of (rd_en[i] & rd_busy[i]).
- we  in  1  writeback enable.
- wb_sel  in  2  0 = ALU, 1 = MEM, 2 = LINK, 3 = reserved.
- wr_addr  in  AW  destination register; ignored when wb_sel = LINK.
- alu_result  in  XLEN  ALU writeback data.
- mem_data  in  XLEN  memory / IO load data.
- pc_plus4  in  XLEN  link value for JAL.
- pend_set  in  1  a long-latency load to pend_addr is issued this cycle.
- pend_addr  in  AW  load destination register.

Behaviour:
- Reset (reset = 0, asynchronous):
  - all registers are cleared to 0.
  - the pending vector is cleared to 0.
  - rd_data therefore reads 0, and rd_busy and stall are 0.
- Effective write address (eff_addr):
  - NREGS-1 when wb_sel = LINK.
  - wr_addr otherwise.
- Effective write data (eff_data):
  - wb_sel = 0 → alu_result; 1 → mem_data; 2 → pc_plus4.
- Write commit (wr_fire):
  - wr_fire = we & (wb_sel != 3) & (eff_addr != 0).
  - On a clock rising edge with wr_fire, reg[eff_addr] <= eff_data.
  - Write latency: 1 cycle. The new value is architecturally visible from the next cycle.
  - wb_sel = 3 with we = 1 is a no-op: no register and no pending bit changes.
- Register 0:
  - hard-wired zero; it reads 0 regardless of any write attempt.
  - it is never marked pending.
- Reads:
  - combinational from rd_addr; 0 cycles latency.
  - all ports are independent; the same address on multiple ports is allowed.
- Scoreboard, on each clock rising edge:
  - if wr_fire, pending[eff_addr] <= 0.
  - if pend_set and pend_addr != 0, pending[pend_addr] <= 1.
  - Same address set and cleared in one edge: set wins (a newer load has claimed the register).
  - pend_set on an already-pending register: it stays 1, with no error.
- rd_busy[i] = pending[rd_addr[i]], subject to the bypass rule under Optional Feature.
- stall is purely combinational from the current state and inputs; no registered output.
- The block holds no FSM beyond the register and pending arrays; hazard control belongs to the instantiating pipeline.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - read port i with rd_addr[i] == eff_addr, wr_fire = 1 and eff_addr != 0 returns eff_data in the same cycle (write-first).
  - rd_busy[i] is forced to 0 in that case, because the pending value is arriving now.
- Undefined:
  - reads return the pre-edge array contents (read-before-write).
  - rd_busy reflects the pending bit as stored.

Decomposition:
- Shared package (defines include): WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LINK = 2'd2, WB_RSVD = 2'd3.
- LINK_REG_IDX is NREGS-1 in this block.
- Sub-module: regfile_scoreboard, holding the pending vector, set/clear priority and per-port busy lookup (NREGS and NUM_RD parameters). The array and mux stay in regfile_mp.

Test Plan:
- Reset assertion:
  - stimulus: write 0xDEADBEEF to r5, then assert reset asynchronously mid-cycle.
  - response: r5 reads 0 immediately, with no clock edge needed; rd_busy = 0.
- Register 0 guard:
  - stimulus: we = 1, wb_sel = ALU, wr_addr = 0, alu_result = 0x12345678.
  - response: r0 still reads 0.
  - stimulus: pend_set to r0.
  - response: stall stays 0.
- Link write:
  - stimulus: wb_sel = LINK, wr_addr = 3, pc_plus4 = 0x00400010.
  - response: r31 = 0x00400010 next cycle; r3 unchanged.
- Load-use stall:
  - stimulus: pend_set r8; next cycle rd_addr[0] = 8, rd_en[0] = 1.
  - response: stall = 1.
  - stimulus: we = 1, wb_sel = MEM, wr_addr = 8, mem_data = 0xA5A5.
  - response with REGFILE_BYPASS_EN: stall drops in that same cycle and rd_data[0] = 0xA5A5.
  - response without REGFILE_BYPASS_EN: stall drops on the following cycle.
- Set/clear collision:
  - stimulus: writeback to r9 and pend_set r9 on the same edge.
  - response: pending[9] = 1 afterwards; r9 holds the written data.
- Reserved select:
  - stimulus: we = 1, wb_sel = 3, wr_addr = 4, with r4 pending.
  - response: r4 value and its pending bit are both unchanged.

Source files
------------

// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file: writeback source
// encodings and the link-register index helper.
package regfile_mp_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_RSVD = 2'd3;

  // JAL always links into the top architectural register
  function automatic int link_reg_idx(input int nregs);
    return nregs - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by long-latency load
// issue and cleared by writeback, with a raw busy lookup per read port.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter  int NREGS  = 32,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,      // active-low, asynchronous
  input  logic                 i_clr_en,
  input  logic [AW-1:0]        i_clr_addr,
  input  logic                 i_set_en,
  input  logic [AW-1:0]        i_set_addr,
  input  logic [NUM_RD*AW-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]    o_busy
);

  logic [NREGS-1:0] r_pend;

  // Clear on writeback, then set on load issue; the later assignment wins so a
  // newer load claiming the same register keeps it pending. r0 never pends.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pend <= '0;
    end else begin
      if (i_clr_en)
        r_pend[i_clr_addr] <= 1'b0;
      if (i_set_en && (i_set_addr != '0))
        r_pend[i_set_addr] <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    assign o_busy[g] = r_pend[i_rd_addr[g*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// N-read / 1-write register file with writeback source mux and load-use
// scoreboard. Define REGFILE_BYPASS_EN for write-first reads (the committing
// writeback is forwarded to matching read ports and clears their busy flag).
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NUM_RD = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,     // active-low, asynchronous
  input  logic [NUM_RD*AW-1:0]   i_rd_addr,
  input  logic [NUM_RD-1:0]      i_rd_en,
  output logic [NUM_RD*XLEN-1:0] o_rd_data,
  output logic [NUM_RD-1:0]      o_rd_busy,
  output logic                   o_stall,
  input  logic                   i_we,
  input  logic [1:0]             i_wb_sel,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [XLEN-1:0]        i_alu_result,
  input  logic [XLEN-1:0]        i_mem_data,
  input  logic [XLEN-1:0]        i_pc_plus4,
  input  logic                   i_pend_set,
  input  logic [AW-1:0]          i_pend_addr
);

  localparam logic [AW-1:0] LINK_IDX = AW'(link_reg_idx(NREGS));

  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic [AW-1:0]              w_eff_addr;
  logic [XLEN-1:0]            w_eff_data;
  logic                       w_wr_fire;
  logic [NUM_RD-1:0]          w_busy_raw;

  assign w_eff_addr = (i_wb_sel == WB_LINK) ? LINK_IDX : i_wr_addr;
  assign w_wr_fire  = i_we && (i_wb_sel != WB_RSVD) && (w_eff_addr != '0);

  // Writeback source select; the reserved code never commits so its data is don't-care
  always_comb begin
    w_eff_data = i_alu_result;
    case (i_wb_sel)
      WB_MEM:  w_eff_data = i_mem_data;
      WB_LINK: w_eff_data = i_pc_plus4;
      default: w_eff_data = i_alu_result;
    endcase
  end

  // Register array; r0 stays zero because wr_fire excludes address 0
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset)
      r_regs <= '0;
    else if (w_wr_fire)
      r_regs[w_eff_addr] <= w_eff_data;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clr_en   (w_wr_fire),
    .i_clr_addr (w_eff_addr),
    .i_set_en   (i_pend_set),
    .i_set_addr (i_pend_addr),
    .i_rd_addr  (i_rd_addr),
    .o_busy     (w_busy_raw)
  );

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_arr;
    assign w_ra  = i_rd_addr[g*AW +: AW];
    assign w_arr = r_regs[w_ra];
`ifdef REGFILE_BYPASS_EN
    logic w_hit;
    assign w_hit                    = w_wr_fire && (w_ra == w_eff_addr);
    assign o_rd_data[g*XLEN +: XLEN] = w_hit ? w_eff_data : w_arr;
    assign o_rd_busy[g]              = w_busy_raw[g] && !w_hit;
`else
    assign o_rd_data[g*XLEN +: XLEN] = w_arr;
    assign o_rd_busy[g]              = w_busy_raw[g];
`endif
  end

  assign o_stall = |(i_rd_en & o_rd_busy);

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (default parameters): directed table,
// randomized traffic against a behavioural model, and multi-cycle corner cases.
module tb_regfile_mp;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_en;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        stall;
  logic        we;
  logic [1:0]  wb_sel;
  logic [4:0]  wr_addr;
  logic [31:0] alu_result, mem_data, pc_plus4;
  logic        pend_set;
  logic [4:0]  pend_addr;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_reg [32];
  bit          m_pend[32];

  regfile_mp dut (
    .i_clock      (clock),
    .i_reset      (reset_n),
    .i_rd_addr    (rd_addr),
    .i_rd_en      (rd_en),
    .o_rd_data    (rd_data),
    .o_rd_busy    (rd_busy),
    .o_stall      (stall),
    .i_we         (we),
    .i_wb_sel     (wb_sel),
    .i_wr_addr    (wr_addr),
    .i_alu_result (alu_result),
    .i_mem_data   (mem_data),
    .i_pc_plus4   (pc_plus4),
    .i_pend_set   (pend_set),
    .i_pend_addr  (pend_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [1:0]  sel;
    logic [4:0]  wa;
    logic [31:0] alu, mem, pc;
    logic        ps;
    logic [4:0]  pa, ra0, ra1;
    logic [1:0]  en;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_busy;
    logic        e_stall;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] s, input logic [4:0] wa,
                       input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                       input logic ps, input logic [4:0] pa,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] e);
    we = w; wb_sel = s; wr_addr = wa; alu_result = a; mem_data = m; pc_plus4 = p;
    pend_set = ps; pend_addr = pa; rd_addr = {r1, r0}; rd_en = e;
  endtask

  function automatic int m_ea();
    return (wb_sel == 2'd2) ? 31 : int'(wr_addr);
  endfunction

  function automatic logic [31:0] m_ed();
    case (wb_sel)
      2'd1:    return mem_data;
      2'd2:    return pc_plus4;
      default: return alu_result;
    endcase
  endfunction

  function automatic bit m_fire();
    return we && (wb_sel != 2'd3) && (m_ea() != 0);
  endfunction

  function automatic logic [31:0] m_rd(input int a);
`ifdef REGFILE_BYPASS_EN
    if (m_fire() && a == m_ea()) return m_ed();
`endif
    return (a == 0) ? 32'h0 : m_reg[a];
  endfunction

  function automatic bit m_busy(input int a);
`ifdef REGFILE_BYPASS_EN
    if (m_fire() && a == m_ea()) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_pend[i] = 1'b0; end
  endtask

  // Commit the model from the inputs held across the coming edge, then advance
  task automatic tick();
    if (m_fire()) begin m_reg[m_ea()] = m_ed(); m_pend[m_ea()] = 1'b0; end
    if (pend_set && pend_addr != 0) m_pend[pend_addr] = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    logic [4:0] ra0, ra1;
    logic [1:0] eb;
    logic       es;

    tbl[0] = '{1'b1, 2'd0, 5'd5, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd0, 5'd6, 2'b11, 32'h0,  32'h0, 2'b00, 1'b0};
    tbl[1] = '{1'b1, 2'd1, 5'd6, 32'h0,  32'h22, 32'h0,  1'b1, 5'd7, 5'd5, 5'd7, 2'b11, 32'h11, 32'h0, 2'b00, 1'b0};
    tbl[2] = '{1'b1, 2'd2, 5'd3, 32'h0,  32'h0,  32'h33, 1'b0, 5'd0, 5'd6, 5'd7, 2'b01, 32'h22, 32'h0, 2'b10, 1'b0};
    tbl[3] = '{1'b1, 2'd3, 5'd7, 32'h99, 32'h0,  32'h0,  1'b0, 5'd0, 5'd31,5'd7, 2'b11, 32'h33, 32'h0, 2'b10, 1'b1};
    tbl[4] = '{1'b0, 2'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b1, 5'd0, 5'd7, 5'd3, 2'b11, 32'h0,  32'h0, 2'b01, 1'b1};
    tbl[5] = '{1'b1, 2'd0, 5'd0, 32'h55, 32'h0,  32'h0,  1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 32'h0,  32'h0, 2'b00, 1'b0};
    tbl[6] = '{1'b0, 2'd0, 5'd0, 32'h0,  32'h0,  32'h0,  1'b0, 5'd0, 5'd0, 5'd7, 2'b10, 32'h0,  32'h0, 2'b10, 1'b1};

    reset_n = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd31, 2'b11);
    m_clear();
    repeat (2) @(negedge clock);
    chk("reset_rd0", rd_data[31:0], 32'h0);
    chk("reset_rd1", rd_data[63:32], 32'h0);
    chk("reset_busy", {30'h0, rd_busy}, 32'h0);
    chk("reset_stall", {31'h0, stall}, 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].we, tbl[i].sel, tbl[i].wa, tbl[i].alu, tbl[i].mem, tbl[i].pc,
            tbl[i].ps, tbl[i].pa, tbl[i].ra0, tbl[i].ra1, tbl[i].en);
      #1;
      chk($sformatf("tbl%0d_rd0", i), rd_data[31:0], tbl[i].e_rd0);
      chk($sformatf("tbl%0d_rd1", i), rd_data[63:32], tbl[i].e_rd1);
      chk($sformatf("tbl%0d_busy", i), {30'h0, rd_busy}, {30'h0, tbl[i].e_busy});
      chk($sformatf("tbl%0d_stall", i), {31'h0, stall}, {31'h0, tbl[i].e_stall});
      tick();
    end

    // Randomized traffic, addresses biased low so reads hit writes and pends
    for (int c = 0; c < 400; c++) begin
      ra0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
            $urandom, $urandom, $urandom, 1'($urandom_range(0, 2) == 0),
            5'($urandom_range(0, 7)), ra0, ra1, 2'($urandom_range(0, 3)));
      #1;
      eb = {m_busy(int'(ra1)), m_busy(int'(ra0))};
      es = |(rd_en & eb);
      chk($sformatf("rnd%0d_rd0", c), rd_data[31:0], m_rd(int'(ra0)));
      chk($sformatf("rnd%0d_rd1", c), rd_data[63:32], m_rd(int'(ra1)));
      chk($sformatf("rnd%0d_busy", c), {30'h0, rd_busy}, {30'h0, eb});
      chk($sformatf("rnd%0d_stall", c), {31'h0, stall}, {31'h0, es});
      tick();
    end

    // Asynchronous reset mid-cycle
    drive(1'b1, 2'd0, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 5'd6, 5'd5, 5'd6, 2'b11);
    tick();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd6, 2'b11);
    #1;
    chk("pre_reset_r5", rd_data[31:0], 32'hDEADBEEF);
    chk("pre_reset_busy", {30'h0, rd_busy}, 32'h2);
    #1 reset_n = 1'b0;
    #1;
    chk("async_reset_r5", rd_data[31:0], 32'h0);
    chk("async_reset_busy", {30'h0, rd_busy}, 32'h0);
    chk("async_reset_stall", {31'h0, stall}, 32'h0);
    m_clear();
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // r0 guard: writes and pends to r0 have no effect
    drive(1'b1, 2'd0, 5'd0, 32'h12345678, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11);
    tick();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11);
    #1 chk("r0_read", rd_data[31:0], 32'h0);
    tick();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11);
    #1 chk("r0_stall", {31'h0, stall}, 32'h0);

    // Link write lands in r31, not in wr_addr
    drive(1'b1, 2'd0, 5'd3, 32'h77, 32'h0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd3, 2'b00);
    tick();
    drive(1'b1, 2'd2, 5'd3, 32'h0, 32'h0, 32'h00400010, 1'b0, 5'd0, 5'd31, 5'd3, 2'b00);
    tick();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd3, 2'b00);
    #1;
    chk("link_r31", rd_data[31:0], 32'h00400010);
    chk("link_r3", rd_data[63:32], 32'h77);

    // Load-use stall and its release
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd8, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd8, 5'd0, 2'b01);
    #1 chk("lu_stall", {31'h0, stall}, 32'h1);
    drive(1'b1, 2'd1, 5'd8, 32'h0, 32'hA5A5, 32'h0, 1'b0, 5'd0, 5'd8, 5'd0, 2'b01);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("lu_wb_stall", {31'h0, stall}, 32'h0);
    chk("lu_wb_rd0", rd_data[31:0], 32'hA5A5);
`else
    chk("lu_wb_stall", {31'h0, stall}, 32'h1);
    chk("lu_wb_rd0", rd_data[31:0], 32'h0);
`endif
    tick();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd8, 5'd0, 2'b01);
    #1;
    chk("lu_after_stall", {31'h0, stall}, 32'h0);
    chk("lu_after_rd0", rd_data[31:0], 32'hA5A5);

    // Set and clear of r9 on the same edge: set wins, data still written
    drive(1'b1, 2'd0, 5'd9, 32'h99, 32'h0, 32'h0, 1'b1, 5'd9, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 2'b01);
    #1;
    chk("coll_r9", rd_data[31:0], 32'h99);
    chk("coll_busy", {30'h0, rd_busy}, 32'h1);
    chk("coll_stall", {31'h0, stall}, 32'h1);

    // Reserved select leaves a pending r4 untouched
    drive(1'b1, 2'd0, 5'd4, 32'h44, 32'h0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd0, 2'b00);
    tick();
    drive(1'b1, 2'd3, 5'd4, 32'hFFFF, 32'hFFFF, 32'hFFFF, 1'b0, 5'd0, 5'd4, 5'd0, 2'b01);
    tick();
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 2'b01);
    #1;
    chk("rsvd_r4", rd_data[31:0], 32'h44);
    chk("rsvd_busy", {30'h0, rd_busy}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
